// File: rtl/axistream_unpack_keep_if.sv
// ---------------------------------------------------------------------------
// axistream_unpack_keep_if
// Bundles the wide AXI-Stream source channel, the narrow AXI-Stream dest
// channel and the null_last indication of the unpacker.
//   slave  : the unpacker's view (consumes src, produces dest)
//   master : the environment's view (produces src, consumes dest)
// Signals:
//   src_tvalid/src_tready/src_tdata/src_tkeep/src_tlast   wide input beat
//   dest_tvalid/dest_tready/dest_tdata/dest_tlast         narrow output word
//   null_last                                             dropped tlast pulse
// ---------------------------------------------------------------------------
interface axistream_unpack_keep_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4
);
    logic                           src_tvalid;
    logic                           src_tready;
    logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata;
    logic [NUM_PACK-1:0]            src_tkeep;
    logic                           src_tlast;
    logic                           dest_tvalid;
    logic                           dest_tready;
    logic [DATA_WIDTH-1:0]          dest_tdata;
    logic                           dest_tlast;
    logic                           null_last;

    modport slave (
        input  src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tlast, null_last
    );

    modport master (
        output src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tlast, null_last
    );
endinterface

// File: rtl/axistream_unpack_keep.sv
// ---------------------------------------------------------------------------
// axistream_unpack_keep
// Splits each NUM_PACK-word source beat into single DATA_WIDTH words on the
// dest channel, skipping words whose tkeep bit is clear. Null beats
// (tkeep==0) are consumed silently; a null beat carrying tlast raises a
// one-cycle null_last pulse because that tlast cannot be attached to a word.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        axistream_unpack_keep_if.slave (src / dest / null_last)
//   drop_cnt   [15:0] saturating count of null beats, present only when
//              AXISTREAM_UNPACK_KEEP_DROPCNT_EN is defined
// Parameters:
//   DATA_WIDTH  output word width
//   NUM_PACK    words per source beat (>=2)
//   BIG_ENDIAN  0: word 0 (LSBs) first, 1: word NUM_PACK-1 (MSBs) first
// ---------------------------------------------------------------------------
module axistream_unpack_keep #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    axistream_unpack_keep_if.slave       bus
`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_PACK);

    logic [DATA_WIDTH*NUM_PACK-1:0] r_data_buf;
    logic [NUM_PACK-1:0]            r_rem_mask;
    logic                           r_tlast_buf;
    logic                           r_null_last;

    logic [IDX_W-1:0]               w_sel;
    logic [NUM_PACK-1:0]            w_sel_oh;
    logic [DATA_WIDTH-1:0]          w_word;
    logic                           w_last_word;
    logic                           w_dest_tvalid;
    logic                           w_dest_hs;
    logic                           w_src_tready;
    logic                           w_src_hs;
    logic                           w_src_null;

    // Priority-encode the next word to send and mux it out of the buffer.
    always_comb begin
        w_sel    = '0;
        w_sel_oh = '0;
        w_word   = '0;
        if (BIG_ENDIAN == 1'b0) begin
            // Descending scan: the last hit is the lowest set bit.
            for (int i = NUM_PACK - 1; i >= 0; i--) begin
                if (r_rem_mask[i]) begin
                    w_sel = IDX_W'(i);
                end else begin
                    w_sel = w_sel;
                end
            end
        end else begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < NUM_PACK; i++) begin
                if (r_rem_mask[i]) begin
                    w_sel = IDX_W'(i);
                end else begin
                    w_sel = w_sel;
                end
            end
        end
        for (int i = 0; i < NUM_PACK; i++) begin
            if (IDX_W'(i) == w_sel) begin
                w_word      = r_data_buf[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_oh[i] = 1'b1;
            end else begin
                w_word = w_word;
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign w_last_word   = (r_rem_mask != '0) &&
                           ((r_rem_mask & (r_rem_mask - NUM_PACK'(1))) == '0);
    assign w_dest_tvalid = !rst && (r_rem_mask != '0);
    assign w_dest_hs     = w_dest_tvalid && bus.dest_tready;
    // Accept a new beat when empty, or when the final word drains this cycle.
    assign w_src_tready  = !rst && ((r_rem_mask == '0) || (w_dest_hs && w_last_word));
    assign w_src_hs      = bus.src_tvalid && w_src_tready;
    assign w_src_null    = (bus.src_tkeep == '0);

    assign bus.src_tready  = w_src_tready;
    assign bus.dest_tvalid = w_dest_tvalid;
    assign bus.dest_tdata  = rst ? '0 : w_word;
    assign bus.dest_tlast  = w_dest_tvalid && r_tlast_buf && w_last_word;
    assign bus.null_last   = r_null_last;

    // Beat buffer, remaining-word mask and null_last pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_buf  <= '0;
            r_rem_mask  <= '0;
            r_tlast_buf <= 1'b0;
            r_null_last <= 1'b0;
        end else begin
            if (w_src_hs && !w_src_null) begin
                // A load overrides the clear of the word draining this cycle.
                r_data_buf  <= bus.src_tdata;
                r_rem_mask  <= bus.src_tkeep;
                r_tlast_buf <= bus.src_tlast;
            end else if (w_dest_hs) begin
                r_rem_mask  <= r_rem_mask & ~w_sel_oh;
            end else begin
                r_rem_mask  <= r_rem_mask;
            end
            r_null_last <= w_src_hs && w_src_null && bus.src_tlast;
        end
    end

`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of every consumed null beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_src_hs && w_src_null && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_axistream_unpack_keep.sv
// ---------------------------------------------------------------------------
// tb_axistream_unpack_keep
// Two unpackers (little- and big-endian) share one stimulus stream. Each
// accepted beat is expanded by a reference model into the expected word
// sequence per instance; a negedge monitor pops and compares whenever a dest
// word is presented, and also predicts src_tready, null_last and drop_cnt
// from the number of words still owed.
// ---------------------------------------------------------------------------
module tb_axistream_unpack_keep;
    localparam int DW = 8;
    localparam int NP = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axistream_unpack_keep_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) if_le ();
    axistream_unpack_keep_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) if_be ();

    assign if_be.src_tvalid  = if_le.src_tvalid;
    assign if_be.src_tdata   = if_le.src_tdata;
    assign if_be.src_tkeep   = if_le.src_tkeep;
    assign if_be.src_tlast   = if_le.src_tlast;
    assign if_be.dest_tready = if_le.dest_tready;

`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
    logic [15:0] drop0, drop1;
`endif

    axistream_unpack_keep #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) u_le (
        .clk (clk),
        .rst (rst),
        .bus (if_le.slave)
`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
        , .drop_cnt (drop0)
`endif
    );

    axistream_unpack_keep #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) u_be (
        .clk (clk),
        .rst (rst),
        .bus (if_be.slave)
`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
        , .drop_cnt (drop1)
`endif
    );

    logic          o_v [2];
    logic          o_r [2];
    logic          o_l [2];
    logic          o_n [2];
    logic [DW-1:0] o_d [2];
    assign o_v[0] = if_le.dest_tvalid;
    assign o_v[1] = if_be.dest_tvalid;
    assign o_r[0] = if_le.src_tready;
    assign o_r[1] = if_be.src_tready;
    assign o_l[0] = if_le.dest_tlast;
    assign o_l[1] = if_be.dest_tlast;
    assign o_n[0] = if_le.null_last;
    assign o_n[1] = if_be.null_last;
    assign o_d[0] = if_le.dest_tdata;
    assign o_d[1] = if_be.dest_tdata;

    word_t q_le[$];
    word_t q_be[$];
    int    vectors  = 0;
    int    errors   = 0;
    int    cyc      = 0;
    bit    rdy_rand = 1'b0;
    bit    null_pend = 1'b0;
    int    drop_pend = 0;
    int    exp_drop  = 0;
    bit    valid_at[int];
    bit    stalled [2];
    logic [DW-1:0] held_d [2];
    logic          held_l [2];

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", name, inst, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q_le.size() : q_be.size();
    endfunction

    function automatic word_t qfront(input int i);
        return (i == 0) ? q_le[0] : q_be[0];
    endfunction

    task automatic qpop(input int i);
        word_t w;
        if (i == 0) w = q_le.pop_front();
        else        w = q_be.pop_front();
    endtask

    // Reference model: kept words in ascending (LE) / descending (BE) index
    // order; tlast rides on the final kept word of the beat.
    task automatic model_beat(input logic [DW*NP-1:0] d, input logic [NP-1:0] k,
                              input logic l);
        word_t w;
        int    n;
        n = 0;
        for (int i = 0; i < NP; i++) if (k[i]) n++;
        if (n == 0) begin
            drop_pend++;
            if (l) null_pend = 1'b1;
        end else begin
            int c;
            c = 0;
            for (int i = 0; i < NP; i++) begin
                if (k[i]) begin
                    c++;
                    w.d = d[i*DW +: DW];
                    w.l = l && (c == n);
                    q_le.push_back(w);
                end
            end
            c = 0;
            for (int i = NP - 1; i >= 0; i--) begin
                if (k[i]) begin
                    c++;
                    w.d = d[i*DW +: DW];
                    w.l = l && (c == n);
                    q_be.push_back(w);
                end
            end
        end
    endtask

    task automatic send_beat(input logic [DW*NP-1:0] d, input logic [NP-1:0] k,
                             input logic l, output int hs_cyc);
        bit ok;
        ok = 1'b0;
        hs_cyc = -1;
        if_le.src_tvalid = 1'b1;
        if_le.src_tdata  = d;
        if_le.src_tkeep  = k;
        if_le.src_tlast  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (if_le.src_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            hs_cyc = cyc;
            model_beat(d, k, l);
        end else begin
            vectors++;
            errors++;
            $display("FAIL src_accept_timeout got=0 exp=1 t=%0t", $time);
        end
        @(posedge clk);
        #1;
        if_le.src_tvalid = 1'b0;
        if_le.src_tdata  = $urandom;
        if_le.src_tkeep  = NP'($urandom);
        if_le.src_tlast  = 1'($urandom);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Dest backpressure: always ready, or randomly stalled.
    initial begin
        if_le.dest_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if_le.dest_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compare everything the DUTs present against the model.
    initial forever begin
        @(negedge clk);
        if (rst) exp_drop = 0;
        else begin
            exp_drop = exp_drop + drop_pend;
            if (exp_drop > 65535) exp_drop = 65535;
        end
        drop_pend = 0;
        for (int i = 0; i < 2; i++) begin
            int    n;
            word_t w;
            n = qsize(i);
            chk("src_tready", i, 32'(o_r[i]),
                32'(!rst && (n == 0 || (n == 1 && if_le.dest_tready))));
            chk("dest_tvalid", i, 32'(o_v[i]), 32'(!rst && n != 0));
            chk("null_last", i, 32'(o_n[i]), 32'(!rst && null_pend));
`ifdef AXISTREAM_UNPACK_KEEP_DROPCNT_EN
            chk("drop_cnt", i, 32'((i == 0) ? drop0 : drop1), 32'(exp_drop));
`endif
            if (rst) begin
                chk("rst_tdata", i, 32'(o_d[i]), 32'h0);
                chk("rst_tlast", i, 32'(o_l[i]), 32'h0);
                stalled[i] = 1'b0;
            end else if (o_v[i] && n != 0) begin
                w = qfront(i);
                if (stalled[i]) begin
                    chk("stall_data", i, 32'(o_d[i]), 32'(held_d[i]));
                    chk("stall_last", i, 32'(o_l[i]), 32'(held_l[i]));
                end
                chk("dest_tdata", i, 32'(o_d[i]), 32'(w.d));
                chk("dest_tlast", i, 32'(o_l[i]), 32'(w.l));
                if (if_le.dest_tready) begin
                    qpop(i);
                    stalled[i] = 1'b0;
                end else begin
                    stalled[i] = 1'b1;
                    held_d[i]  = o_d[i];
                    held_l[i]  = o_l[i];
                end
            end else begin
                stalled[i] = 1'b0;
            end
        end
        null_pend = 1'b0;
        valid_at[cyc] = o_v[0] && o_v[1];
    end

    initial begin
        int h0, h;
        int budget;
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
        if_le.src_tvalid = 1'b0;
        if_le.src_tdata  = '0;
        if_le.src_tkeep  = '0;
        if_le.src_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full beat, then sparse beat.
        send_beat(32'h44332211, 4'hF, 1'b1, h);
        send_beat(32'hDDCCBBAA, 4'b1010, 1'b1, h);
        // Null tlast beat between two full beats.
        send_beat(32'h0D0C0B0A, 4'hF, 1'b0, h);
        send_beat(32'hFFFFFFFF, 4'h0, 1'b1, h);
        send_beat(32'h1D1C1B1A, 4'hF, 1'b1, h);
        repeat (6) @(posedge clk);
        #1;

        // Three back-to-back full beats: dest_tvalid unbroken for 12 cycles.
        send_beat(32'h03020100, 4'hF, 1'b0, h0);
        send_beat(32'h07060504, 4'hF, 1'b0, h);
        send_beat(32'h0B0A0908, 4'hF, 1'b1, h);
        repeat (8) @(posedge clk);
        #1;
        if (h0 >= 0) begin
            for (int c = h0 + 1; c <= h0 + 12; c++)
                chk("b2b_valid", c - h0, 32'(valid_at.exists(c) && valid_at[c]), 32'h1);
        end

        // Randomized beats with random gaps and backpressure.
        rdy_rand = 1'b1;
        for (int b = 0; b < 150; b++) begin
            send_beat(32'($urandom), NP'($urandom_range(0, 15)), 1'($urandom), h);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Reset after the 2nd word of a beat, then a fresh beat.
        send_beat(32'h9C9B9A99, 4'hF, 1'b1, h);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 0, 32'(if_le.dest_tvalid), 32'h0);
        chk("async_rst_valid", 1, 32'(if_be.dest_tvalid), 32'h0);
        chk("async_rst_tdata", 0, 32'(if_le.dest_tdata), 32'h0);
        chk("async_rst_tdata", 1, 32'(if_be.dest_tdata), 32'h0);
        chk("async_rst_ready", 0, 32'(if_le.src_tready), 32'h0);
        chk("async_rst_tlast", 1, 32'(if_be.dest_tlast), 32'h0);
        q_le.delete();
        q_be.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(32'hD4C3B2A1, 4'hF, 1'b1, h);

        // Drain with a bounded wait.
        budget = 0;
        while ((q_le.size() != 0 || q_be.size() != 0) && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        chk("drain_le", 0, 32'(q_le.size()), 32'h0);
        chk("drain_be", 1, 32'(q_be.size()), 32'h0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
